// File: rtl/permutation_iter_pkg.sv
// Shared types, defaults and pure round-function helpers for the iterative Ascon permutation.
// Word [0] of type_state is the most significant 64 bits of the packed 320-bit vector.
package permutation_iter_pkg;

  typedef logic [0:4][63:0] type_state;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } type_perm_fsm;

  localparam int         DEF_ROUNDS_A = 12;
  localparam int         DEF_ROUNDS_B = 6;
  localparam logic [3:0] LAST_ROUND   = 4'd11;

  // Round constant for round index r: high nibble counts down while low nibble counts up.
  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Bitsliced 5-bit S-box applied to all 64 columns at once.
  function automatic type_state substitution_layer(input type_state s);
    type_state   o;
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0] ^ s[4];
    x1 = s[1];
    x2 = s[2] ^ s[1];
    x3 = s[3];
    x4 = s[4] ^ s[3];
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    o[0] = x0;
    o[1] = x1;
    o[2] = x2;
    o[3] = x3;
    o[4] = x4;
    return o;
  endfunction

  function automatic type_state diffusion_layer(input type_state s);
    type_state o;
    o[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
    o[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
    o[2] = s[2] ^ ror64(s[2], 1)  ^ ror64(s[2], 6);
    o[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
    o[4] = s[4] ^ ror64(s[4], 7)  ^ ror64(s[4], 41);
    return o;
  endfunction

endpackage

// File: rtl/permutation_iter_if.sv
// Start/done handshake and state bus of the permutation core.
// Macro PERM_XOR_IN_EN adds the xor_en_i/xor_data_i absorption inputs.
interface permutation_iter_if;
  import permutation_iter_pkg::*;

  // Handshake: start_i is a one-cycle request honoured only while busy_o=0
  // (including the done_o cycle); mode_i/state_i are sampled on that edge.
  // done_o pulses for one cycle when state_o holds the result.
  logic         start_i;
  logic         mode_i;
  type_state    state_i;
`ifdef PERM_XOR_IN_EN
  logic         xor_en_i;
  logic [63:0]  xor_data_i;
`endif
  type_state    state_o;
  logic [3:0]   round_o;
  logic         busy_o;
  logic         done_o;
  type_perm_fsm fsm_o;

`ifdef PERM_XOR_IN_EN
  modport master (
    output start_i, mode_i, state_i, xor_en_i, xor_data_i,
    input  state_o, round_o, busy_o, done_o, fsm_o
  );
  modport slave (
    input  start_i, mode_i, state_i, xor_en_i, xor_data_i,
    output state_o, round_o, busy_o, done_o, fsm_o
  );
`else
  modport master (
    output start_i, mode_i, state_i,
    input  state_o, round_o, busy_o, done_o, fsm_o
  );
  modport slave (
    input  start_i, mode_i, state_i,
    output state_o, round_o, busy_o, done_o, fsm_o
  );
`endif

endinterface

// File: rtl/permutation_iter_round.sv
// One combinational Ascon round: constant addition, substitution layer, diffusion layer.
module permutation_iter_round
  import permutation_iter_pkg::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  type_state added;
  type_state subst;

  // Only the low byte of word 2 receives the constant; no carries into bits [63:8].
  always_comb begin
    added          = state_i;
    added[2][7:0]  = state_i[2][7:0] ^ rc(round_i);
  end

  assign subst   = substitution_layer(added);
  assign state_o = diffusion_layer(subst);

endmodule

// File: rtl/permutation_iter.sv
// Iterative Ascon permutation p^a / p^b, one round per clock, start/done handshake.
// Optional macro PERM_XOR_IN_EN: XOR xor_data_i into word 0 of state_i on an accepted start.
module permutation_iter
  import permutation_iter_pkg::*;
#(
  parameter int ROUNDS_A = DEF_ROUNDS_A,
  parameter int ROUNDS_B = DEF_ROUNDS_B
) (
  input logic               clock_i,
  input logic               reset_i,
  permutation_iter_if.slave perm
);

  localparam logic [3:0] FIRST_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] FIRST_B = 4'(12 - ROUNDS_B);

  type_perm_fsm fsm_q, fsm_d;
  type_state    state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  type_state    seed;
  type_state    round_in_state;
  type_state    round_out_state;
  logic [3:0]   round_in;

  always_comb begin
    seed = perm.state_i;
`ifdef PERM_XOR_IN_EN
    if (perm.xor_en_i) seed[0] = perm.state_i[0] ^ perm.xor_data_i;
`endif
  end

  // IDLE (including the done cycle) feeds the fresh input; RUN feeds the register back.
  assign round_in_state = (fsm_q == IDLE) ? seed : state_q;
  assign round_in       = (fsm_q == IDLE) ? (perm.mode_i ? FIRST_B : FIRST_A)
                                          : round_q + 4'd1;

  permutation_iter_round u_round (
    .state_i (round_in_state),
    .round_i (round_in),
    .state_o (round_out_state)
  );

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (perm.start_i) begin
          state_d = round_out_state;
          round_d = round_in;
          if (round_in == LAST_ROUND) done_d = 1'b1;
          else                        fsm_d  = RUN;
        end
      end
      RUN: begin
        state_d = round_out_state;
        round_d = round_in;
        if (round_in == LAST_ROUND) begin
          fsm_d  = IDLE;
          done_d = 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign perm.state_o = state_q;
  assign perm.round_o = round_q;
  assign perm.busy_o  = (fsm_q == RUN);
  assign perm.done_o  = done_q;
  assign perm.fsm_o   = fsm_q;

endmodule

// File: tb/tb_permutation_iter.sv
// Scoreboard bench for permutation_iter: table-driven S-box reference model, monitor on done_o.
module tb_permutation_iter;
  import permutation_iter_pkg::*;

  localparam int W  = 324;
  localparam int NA = 12;
  localparam int NB = 6;
`ifdef PERM_XOR_IN_EN
  localparam bit XOR_ON = 1'b1;
`else
  localparam bit XOR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  permutation_iter_if pif ();

  permutation_iter dut (
    .clock_i (clk),
    .reset_i (rst),
    .perm    (pif)
  );

  logic [W-1:0] exp_q[$];
  type_state    exp_last;
  int           tests = 0;
  int           fails = 0;

  logic [4:0] sbox_t [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(logic [63:0] x, int n);
    logic [127:0] d;
    d = {x, x};
    return d[n +: 64];
  endfunction

  function automatic type_state ref_round(type_state s, int r);
    type_state  o;
    logic [4:0] col, sc;
    s[2] = s[2] ^ 64'(((15 - r) << 4) + r);
    for (int j = 0; j < 64; j++) begin
      col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      sc  = sbox_t[col];
      for (int w = 0; w < 5; w++) o[w][j] = sc[4-w];
    end
    o[0] = o[0] ^ rotr(o[0], 19) ^ rotr(o[0], 28);
    o[1] = o[1] ^ rotr(o[1], 61) ^ rotr(o[1], 39);
    o[2] = o[2] ^ rotr(o[2], 1)  ^ rotr(o[2], 6);
    o[3] = o[3] ^ rotr(o[3], 10) ^ rotr(o[3], 17);
    o[4] = o[4] ^ rotr(o[4], 7)  ^ rotr(o[4], 41);
    return o;
  endfunction

  function automatic type_state ref_perm(type_state s, logic mode, logic xen, logic [63:0] xd);
    int n;
    n = mode ? NB : NA;
    if (xen) s[0] = s[0] ^ xd;
    for (int r = 12 - n; r < 12; r++) s = ref_round(s, r);
    return s;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  // ---------------- checking ----------------
  task automatic check(string name, logic [335:0] act, logic [335:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pif.done_o) begin
      if (exp_q.size() == 0) check("spurious_done", 336'(pif.done_o), '0);
      else check("result", {pif.state_o, pif.round_o}, exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_junk();
    pif.mode_i  = 1'($urandom);
    pif.state_i = rand_state();
`ifdef PERM_XOR_IN_EN
    pif.xor_en_i   = 1'($urandom);
    pif.xor_data_i = {$urandom, $urandom};
`endif
  endtask

  task automatic launch(logic mode, type_state st, logic xen, logic [63:0] xd);
    exp_last = ref_perm(st, mode, XOR_ON && xen, xd);
    exp_q.push_back({exp_last, 4'd11});
    pif.start_i = 1'b1;
    pif.mode_i  = mode;
    pif.state_i = st;
`ifdef PERM_XOR_IN_EN
    pif.xor_en_i   = xen;
    pif.xor_data_i = xd;
`endif
    @(posedge clk); #1;
    pif.start_i = 1'b0;
    drive_junk();
  endtask

  // Returns #1 after the N-th edge, i.e. inside the done cycle.
  task automatic run_full(logic mode, type_state st, logic xen, logic [63:0] xd, int glitch_k);
    int n, r0;
    n  = mode ? NB : NA;
    r0 = 12 - n;
    launch(mode, st, xen, xd);
    for (int k = 1; k <= n; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
        pif.start_i = 1'b0;
      end
      check("timing", {pif.round_o, pif.busy_o, pif.done_o},
            {4'(r0 + k - 1), (k < n), (k == n)});
      if (k == glitch_k) begin
        pif.start_i = 1'b1;
        pif.mode_i  = ~mode;
        pif.state_i = rand_state();
      end
    end
  endtask

  task automatic idle_hold(int gap);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check("hold", {pif.state_o, pif.round_o, pif.busy_o, pif.done_o},
            {exp_last, 4'd11, 1'b0, 1'b0});
    end
  endtask

  // ---------------- stimulus ----------------
  type_state init_st, st2, zero_st;

  initial begin
    pif.start_i = 1'b0;
    drive_junk();
    init_st[0] = 64'h80400c0600000000;
    init_st[1] = 64'h0001020304050607;
    init_st[2] = 64'h08090a0b0c0d0e0f;
    init_st[3] = 64'h0001020304050607;
    init_st[4] = 64'h08090a0b0c0d0e0f;
    zero_st = '0;

    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("reset_state", {pif.state_o, pif.round_o, pif.busy_o, pif.done_o}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset in the middle of p^a, round 5
    launch(1'b0, rand_state(), 1'b0, '0);
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_round", 336'(pif.round_o), 336'(5));
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    check("async_reset", {pif.state_o, pif.round_o, pif.busy_o, pif.done_o}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("post_reset_idle", {pif.state_o, pif.round_o, pif.busy_o, pif.done_o}, '0);

    // p^a timing, p^b and p^a on the Ascon-128 init state, constant check with word 2 cleared
    run_full(1'b0, rand_state(), 1'b0, '0, 0);
    idle_hold(2);
    run_full(1'b1, init_st, 1'b0, '0, 0);
    idle_hold(1);
    run_full(1'b0, init_st, 1'b0, '0, 0);
    idle_hold(1);
    st2 = init_st;
    st2[2] = '0;
    run_full(1'b0, st2, 1'b0, '0, 0);
    idle_hold(1);
    run_full(1'b1, zero_st, 1'b0, '0, 0);
    idle_hold(1);

    // start ignored while busy, then back-to-back launches from the done cycle
    run_full(1'b0, rand_state(), 1'b0, '0, 3);
    run_full(1'b1, rand_state(), 1'b0, '0, 2);
    run_full(1'b0, init_st, 1'b0, '0, 0);
    idle_hold(2);

`ifdef PERM_XOR_IN_EN
    run_full(1'b1, zero_st, 1'b1, 64'hFFFFFFFFFFFFFFFF, 0);
    idle_hold(1);
    run_full(1'b1, init_st, 1'b0, 64'hFFFFFFFFFFFFFFFF, 0);
    idle_hold(1);
`endif

    // randomized runs with random gaps (gap 0 = back-to-back)
    for (int i = 0; i < 24; i++) begin
      run_full(1'($urandom), rand_state(), 1'($urandom), {$urandom, $urandom},
               int'($urandom_range(0, 4)));
      idle_hold(int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", 336'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
